// File: rtl/keypad_8bit_pkg.sv
// keypad_8bit shared definitions: key codes, row reset pattern,
// debounce FSM states and the (row,col) -> key code map.
package keypad_8bit_pkg;

  localparam logic [3:0] K_0    = 4'd0;
  localparam logic [3:0] K_1    = 4'd1;
  localparam logic [3:0] K_2    = 4'd2;
  localparam logic [3:0] K_3    = 4'd3;
  localparam logic [3:0] K_4    = 4'd4;
  localparam logic [3:0] K_5    = 4'd5;
  localparam logic [3:0] K_6    = 4'd6;
  localparam logic [3:0] K_7    = 4'd7;
  localparam logic [3:0] K_8    = 4'd8;
  localparam logic [3:0] K_9    = 4'd9;
  localparam logic [3:0] K_A    = 4'd10;
  localparam logic [3:0] K_B    = 4'd11;
  localparam logic [3:0] K_C    = 4'd12;
  localparam logic [3:0] K_D    = 4'd13;
  localparam logic [3:0] K_STAR = 4'd14;
  localparam logic [3:0] K_HASH = 4'd15;

  localparam logic [3:0] ROW_RST = 4'b1110;

  typedef enum logic {
    DB_IDLE,
    DB_HELD
  } db_state_e;

  // idx = 4*row + col
  function automatic logic [3:0] key_code(
    input logic [3:0] idx
  );
    logic [3:0] k;
    unique case (idx)
      4'd0:  k = K_1;
      4'd1:  k = K_2;
      4'd2:  k = K_3;
      4'd3:  k = K_A;
      4'd4:  k = K_4;
      4'd5:  k = K_5;
      4'd6:  k = K_6;
      4'd7:  k = K_B;
      4'd8:  k = K_7;
      4'd9:  k = K_8;
      4'd10: k = K_9;
      4'd11: k = K_C;
      4'd12: k = K_STAR;
      4'd13: k = K_0;
      4'd14: k = K_HASH;
      4'd15: k = K_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_8bit_if.sv
// keypad_8bit pin bundle: COL in, ROW out (active-low),
// ENTRY/BIN_OUT values, VALID pulse, sticky ERR.
interface keypad_8bit_if;

  logic [3:0] COL;
  logic [3:0] ROW;
  logic [7:0] ENTRY;
  logic [7:0] BIN_OUT;
  logic       VALID;
  logic       ERR;

  modport master (
    input  COL,
    output ROW,
    output ENTRY,
    output BIN_OUT,
    output VALID,
    output ERR
  );

  modport slave (
    output COL,
    input  ROW,
    input  ENTRY,
    input  BIN_OUT,
    input  VALID,
    input  ERR
  );

endinterface

// File: rtl/keypad_8bit_key_debounce.sv
// Full-scan snapshot -> single-key detect -> debounce FSM.
// Ports: CLK, CLR_N, scan_done, scan_n (active-low), key, key_stb.
module keypad_8bit_key_debounce
  import keypad_8bit_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        scan_done,
  input  logic [15:0] scan_n,
  output logic [3:0]  key,
  output logic        key_stb
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_SCANS);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    last_q;
  logic [3:0]    key_q;
  logic          stb_q;
  logic          fire;

  logic [15:0] pressed;
  logic        single;
  logic [3:0]  idx;

  assign pressed = ~scan_n;
  assign single  = (pressed != '0) &&
    ((pressed & (pressed - 16'd1)) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (pressed[i]) idx = 4'(i);
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      key_q   <= K_0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= fire;
      if (scan_done) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        last_q  <= idx;
      end
      if (fire) key_q <= key_code(idx);
    end
  end

  // cnt counts matching scans in IDLE and
  // all-released scans in HELD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DB_IDLE: begin
        if (single) begin
          if (cnt_q != '0 && idx == last_q)
            cnt_d = cnt_q + CW'(1);
          else
            cnt_d = CW'(1);
          if (cnt_d == CNT_MAX) begin
            state_d = DB_HELD;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      DB_HELD: begin
        if (pressed == '0) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_MAX) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    fire = scan_done &&
      state_q == DB_IDLE &&
      state_d == DB_HELD;
  end

  assign key     = key_q;
  assign key_stb = stb_q;

endmodule

// File: rtl/keypad_8bit.sv
// 4x4 keypad scanner + decimal accumulator; optional macro
// KEYPAD_BACKSPACE_EN makes 'D' a backspace. Ports: CLK, CLR_N, kp.
module keypad_8bit
  import keypad_8bit_pkg::*;
#(
  parameter int SCAN_MODULO    = 500000,
  parameter int SCAN_W         = 27,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic           CLK,
  input logic           CLR_N,
  keypad_8bit_if.master kp
);

  logic [SCAN_W-1:0] pre_q;
  logic              ce;
  logic [1:0]        row_q;
  logic [3:0]        row_drv_q;
  logic [3:0]        col_s1, col_s2;
  logic [11:0]       snap_q;
  logic              scan_done;

  logic [3:0]  key;
  logic        key_stb;
  logic [7:0]  entry_q;
  logic [1:0]  dcnt_q;
  logic        err_q;
  logic [7:0]  bin_q;
  logic        valid_q;
  logic [11:0] prod;
  logic        is_digit;

  assign ce = (pre_q == SCAN_W'(SCAN_MODULO - 1));
  assign scan_done = ce && (row_q == 2'd3);

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      pre_q     <= '0;
      row_q     <= '0;
      row_drv_q <= ROW_RST;
      col_s1    <= 4'hF;
      col_s2    <= 4'hF;
      snap_q    <= '1;
    end else begin
      col_s1 <= kp.COL;
      col_s2 <= col_s1;
      pre_q  <= ce ? '0 : pre_q + SCAN_W'(1);
      if (ce) begin
        row_q     <= row_q + 2'd1;
        row_drv_q <= {row_drv_q[2:0], row_drv_q[3]};
        unique case (row_q)
          2'd0: snap_q[3:0]  <= col_s2;
          2'd1: snap_q[7:4]  <= col_s2;
          2'd2: snap_q[11:8] <= col_s2;
          default: ;
        endcase
      end
    end
  end

  // row 3 is consumed straight from the synchroniser
  keypad_8bit_key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_db (
    .CLK      (CLK),
    .CLR_N    (CLR_N),
    .scan_done(scan_done),
    .scan_n   ({col_s2, snap_q}),
    .key      (key),
    .key_stb  (key_stb)
  );

  assign prod     = 12'(entry_q) * 12'd10 + 12'(key);
  assign is_digit = (key <= K_9);

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      entry_q <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
      bin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (key_stb) begin
        unique case (1'b1)
          is_digit: begin
            if (dcnt_q != 2'd3 &&
                prod <= 12'd255) begin
              entry_q <= prod[7:0];
              dcnt_q  <= dcnt_q + 2'd1;
            end else begin
              err_q <= 1'b1;
            end
          end
          (key == K_STAR): begin
            entry_q <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
          end
          (key == K_HASH): begin
            bin_q   <= entry_q;
            valid_q <= 1'b1;
            entry_q <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
          end
`ifdef KEYPAD_BACKSPACE_EN
          (key == K_D): begin
            if (dcnt_q != 2'd0) begin
              entry_q <= entry_q / 8'd10;
              dcnt_q  <= dcnt_q - 2'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign kp.ROW     = row_drv_q;
  assign kp.ENTRY   = entry_q;
  assign kp.BIN_OUT = bin_q;
  assign kp.VALID   = valid_q;
  assign kp.ERR     = err_q;

endmodule

// File: tb/tb_keypad_8bit.sv
// keypad_8bit bench: keypad matrix model, scan-level
// reference model, directed + random key sequences.
module tb_keypad_8bit;

  localparam int SM  = 4;
  localparam int DB  = 2;
  localparam int CYC = 4 * SM;

  logic CLK   = 1'b0;
  logic CLR_N = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  col_drv;

  keypad_8bit_if kp ();

  keypad_8bit #(
    .SCAN_MODULO   (SM),
    .SCAN_W        (27),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .kp   (kp)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kp.ROW[r])
        for (int c = 0; c < 4; c++)
          if (pressed[4*r+c]) col_drv[c] = 1'b0;
  end
  assign kp.COL = col_drv;

  string km = "123A456B789C*0#D";

  int n_chk = 0;
  int n_err = 0;

  int m_entry, m_cnt, m_err, m_bin, m_valid;
  bit m_held;
  logic [15:0] hist[$];

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int kidx(input byte ch);
    for (int i = 0; i < 16; i++)
      if (km[i] == ch) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_entry = 0; m_cnt = 0; m_err = 0;
    m_bin = 0; m_valid = 0; m_held = 0;
    hist.delete();
  endtask

  task automatic key_action(input int idx);
    byte ch;
    int d;
    ch = km[idx];
    if (ch >= "0" && ch <= "9") begin
      d = int'(ch) - int'("0");
      if (m_cnt < 3 && m_entry * 10 + d <= 255) begin
        m_entry = m_entry * 10 + d;
        m_cnt++;
      end else begin
        m_err = 1;
      end
    end else if (ch == "*") begin
      m_entry = 0; m_cnt = 0; m_err = 0;
    end else if (ch == "#") begin
      m_bin = m_entry; m_valid = 1;
      m_entry = 0; m_cnt = 0; m_err = 0;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (ch == "D") begin
      if (m_cnt > 0) begin
        m_entry = m_entry / 10;
        m_cnt--;
      end
    end
`endif
  endtask

  // event: last DB scans since entering IDLE are the
  // same single key; leave HELD after DB empty scans
  task automatic model_scan(input logic [15:0] s);
    bit same;
    m_valid = 0;
    hist.push_back(s);
    if (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() == DB) begin
      same = 1;
      foreach (hist[i])
        if (hist[i] != hist[0]) same = 0;
      if (!m_held && same &&
          $countones(hist[0]) == 1) begin
        m_held = 1;
        hist.delete();
        key_action($clog2(s));
      end else if (m_held && same &&
                   hist[0] == '0) begin
        m_held = 0;
        hist.delete();
      end
    end
  endtask

  // one full scan with a fixed pressed set; checks the
  // outcome of the previous scan along the way
  task automatic scan_win(input logic [15:0] s);
    int vc;
    vc = 0;
    pressed = s;
    for (int i = 0; i < CYC; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      vc += int'(kp.VALID);
      if (i == 1) begin
        check("entry", int'(kp.ENTRY), m_entry);
        check("err", int'(kp.ERR), m_err);
        check("bin_out", int'(kp.BIN_OUT), m_bin);
        check("row_onehot",
              $countones(~kp.ROW), 1);
      end
    end
    check("valid_pulses", vc, m_valid);
    model_scan(s);
  endtask

  task automatic press(input byte ch,
                       input int hold,
                       input int rel);
    logic [15:0] s;
    s = 16'(1) << kidx(ch);
    repeat (hold) scan_win(s);
    repeat (rel) scan_win('0);
  endtask

  task automatic keys(input string str);
    for (int i = 0; i < str.len(); i++)
      press(str[i], 3, 3);
  endtask

  task automatic do_reset();
    CLR_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_row", int'(kp.ROW), 4'hE);
    check("rst_entry", int'(kp.ENTRY), 0);
    check("rst_bin", int'(kp.BIN_OUT), 0);
    check("rst_valid", int'(kp.VALID), 0);
    check("rst_err", int'(kp.ERR), 0);
    model_reset();
    CLR_N = 1'b1;
  endtask

  initial begin
    logic [15:0] s;
    byte ch;
    @(negedge CLK);
    do_reset();

    keys("123#");
    check("s1_bin", int'(kp.BIN_OUT), 123);

    keys("256");
    check("s2_entry", int'(kp.ENTRY), 25);
    check("s2_err", int'(kp.ERR), 1);
    keys("#");
    check("s2_bin", int'(kp.BIN_OUT), 25);

    s = 16'(1) << kidx("5");
    for (int i = 0; i < 6; i++)
      scan_win((i % 2 == 0) ? s : '0);
    scan_win(s);
    scan_win('0);
    check("s3_no_evt", int'(kp.ENTRY), 0);
    scan_win(s);
    scan_win(s);
    repeat (3) scan_win('0);
    check("s3_entry", int'(kp.ENTRY), 5);

    keys("*");
    s = (16'(1) << kidx("4")) |
        (16'(1) << kidx("7"));
    repeat (5) scan_win(s);
    press("4", 2, 3);
    check("s4_entry", int'(kp.ENTRY), 4);

    keys("99*#");
    check("s5_bin", int'(kp.BIN_OUT), 0);
    keys("9");
    s = 16'(1) << kidx("8");
    repeat (3) scan_win(s);
    do_reset();
    repeat (3) scan_win(s);
    repeat (3) scan_win('0);
    check("s5_rearm", int'(kp.ENTRY), 8);

    keys("*247D");
`ifdef KEYPAD_BACKSPACE_EN
    check("s6_bs", int'(kp.ENTRY), 24);
`else
    check("s6_nobs", int'(kp.ENTRY), 247);
`endif
    keys("DDD#");

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          ch = km[$urandom_range(0, 15)];
          press(ch, $urandom_range(1, 3),
                $urandom_range(1, 3));
        end
        5: press("#", $urandom_range(2, 3), 2);
        6: begin
          repeat ($urandom_range(1, 3))
            scan_win(16'($urandom & $urandom
                          & $urandom));
        end
        7: begin
          s = 16'(1) << $urandom_range(0, 15);
          repeat ($urandom_range(2, 5))
            scan_win(($urandom_range(0, 1) == 1)
                     ? s : '0);
        end
        default: press(
          km[$urandom_range(0, 15)], 2, 1);
      endcase
    end
    repeat (3) scan_win('0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
